four_input_debouncer: RTL



---
 rtl/four_input_debouncer_if.sv | 24 ++
 rtl/four_input_debouncer.sv | 88 ++++++++
 2 files changed

// File: rtl/four_input_debouncer_if.sv
// Signal bundle between the raw switch inputs and the debounced OR-gate front end.
interface four_input_debouncer_if;
  logic [3:0] raw_in;
  logic [3:0] clean_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [7:0] rise_count;

  modport master (
    output raw_in,
    input  clean_out,
    input  rise_pulse,
    input  fall_pulse,
    input  rise_count
  );

  modport slave (
    input  raw_in,
    output clean_out,
    output rise_pulse,
    output fall_pulse,
    output rise_count
  );
endinterface

// File: rtl/four_input_debouncer.sv
// Four-channel synchronise-and-debounce stage feeding the lab OR gate's A..D inputs.
// Each channel accepts a new level only after it has persisted for STABLE_CYCLES
// synchronised samples, and emits one-cycle rise/fall strobes plus a rise counter.
module four_input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  four_input_debouncer_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [3:0]       r_s1;
  logic [3:0]       r_s2;
  logic [3:0]       r_clean;
  logic [3:0]       r_rise;
  logic [3:0]       r_fall;
  logic [CNT_W-1:0] r_cnt [4];
  logic [7:0]       r_riseCount;

  logic [CNT_W-1:0] w_cntNext [4];
  logic [3:0]       w_cleanNext;
  logic [3:0]       w_riseNext;
  logic [3:0]       w_fallNext;
  logic [2:0]       w_riseTotal;

  // Two-flop synchroniser; only the second stage is trusted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.raw_in;
      r_s2 <= r_s1;
    end
  end

  // Per-channel stability decision: count disagreeing samples, accept on the last one.
  always_comb begin
    w_cleanNext = r_clean;
    w_riseNext  = '0;
    w_fallNext  = '0;
    w_riseTotal = '0;
    for (int i = 0; i < 4; i++) begin
      w_cntNext[i] = '0;
      if (r_s2[i] != r_clean[i]) begin
        if (r_cnt[i] == LP_LAST) begin
          w_cleanNext[i] = r_s2[i];
          w_riseNext[i]  = r_s2[i];
          w_fallNext[i]  = ~r_s2[i];
        end else begin
          w_cntNext[i] = r_cnt[i] + LP_ONE;
        end
      end
      w_riseTotal = w_riseTotal + {2'b00, w_riseNext[i]};
    end
  end

  // Registered levels, strobes and the wrapping rise counter all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
      r_clean     <= '0;
      r_rise      <= '0;
      r_fall      <= '0;
      r_riseCount <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cntNext[i];
      end
      r_clean     <= w_cleanNext;
      r_rise      <= w_riseNext;
      r_fall      <= w_fallNext;
      r_riseCount <= r_riseCount + {5'b00000, w_riseTotal};
    end
  end

  assign bus.clean_out  = r_clean;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.rise_count = r_riseCount;

endmodule
